// File: rtl/clock_controller_pkg.sv
// Shared types and default constants for the CPU clock controller and its bench.
package clock_controller_pkg;

  typedef enum logic [1:0] {
    StStep   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } cc_state_e;

  localparam int unsigned DefaultDivide         = 4;
  localparam int unsigned DefaultDebounceCycles = 16;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer plus debounce counter for a raw asynchronous level input.
module input_debouncer
  import clock_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
  input  logic i_CLOCK,
  input  logic i_RESET,
  input  logic i_RAW,
  output logic o_LEVEL,
  output logic o_RISE
);

  // Counter only has to reach DEBOUNCE_CYCLES-2 before the accepting cycle.
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES - 1) : 1;
  localparam logic [CntW-1:0] CntLast =
      CntW'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);

  logic            meta_q, sync_q, level_q, rise_q;
  logic [CntW-1:0] cnt_q;
  logic            cnt_done;

  assign cnt_done = (DEBOUNCE_CYCLES < 2) || (cnt_q == CntLast);

  always_ff @(posedge i_CLOCK) begin
    if (i_RESET) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q <= i_RAW;
      sync_q <= meta_q;
      rise_q <= 1'b0;
      if (sync_q != level_q) begin
        if (cnt_done) begin
          level_q <= sync_q;
          rise_q  <= sync_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign o_LEVEL = level_q;
  assign o_RISE  = rise_q;

endmodule

// File: rtl/clock_controller.sv
// CPU clock-enable generator: free-run divider, debounced single-step and HALT capture.
module clock_controller
  import clock_controller_pkg::*;
#(
  parameter int unsigned DIVIDE          = DefaultDivide,
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned COUNT_WIDTH     = 16
) (
  input  logic                   i_CLOCK,
  input  logic                   i_RESET,
  input  logic                   i_RUN_MODE,
  input  logic                   i_STEP_BUTTON,
  input  logic                   i_HALT,
  output logic                   o_CPU_CE,
  output logic                   o_HALTED,
  output logic [COUNT_WIDTH-1:0] o_CE_COUNT
);

  localparam int unsigned DivW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(DIVIDE - 1);

  cc_state_e              state_q;
  logic [DivW-1:0]        div_q;
  logic                   ce_q, halted_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   step_req, run_level;
  logic                   step_level_unused, run_rise_unused;
  logic                   div_slot;

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debouncer (
    .i_CLOCK(i_CLOCK),
    .i_RESET(i_RESET),
    .i_RAW  (i_STEP_BUTTON),
    .o_LEVEL(step_level_unused),
    .o_RISE (step_req)
  );

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run_debouncer (
    .i_CLOCK(i_CLOCK),
    .i_RESET(i_RESET),
    .i_RAW  (i_RUN_MODE),
    .o_LEVEL(run_level),
    .o_RISE (run_rise_unused)
  );

  assign div_slot = (div_q == DivLast);

  always_ff @(posedge i_CLOCK) begin
    if (i_RESET) begin
      state_q  <= StStep;
      div_q    <= '0;
      ce_q     <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      ce_q <= 1'b0;
      unique case (state_q)
        StStep: begin
          div_q <= '0;
          if (step_req && i_HALT) begin
            state_q  <= StHalted;
            halted_q <= 1'b1;
          end else begin
            if (step_req) begin
              ce_q    <= 1'b1;
              count_q <= count_q + COUNT_WIDTH'(1);
            end
            if (run_level) state_q <= StRun;
          end
        end
        StRun: begin
          div_q <= div_slot ? '0 : div_q + DivW'(1);
          if (div_slot && i_HALT) begin
            state_q  <= StHalted;
            halted_q <= 1'b1;
          end else begin
            // A CE due on the same cycle the switch drops is still issued.
            if (div_slot) begin
              ce_q    <= 1'b1;
              count_q <= count_q + COUNT_WIDTH'(1);
            end
            if (!run_level) begin
              state_q <= StStep;
              div_q   <= '0;
            end
          end
        end
        StHalted: begin
          halted_q <= 1'b1;
        end
        default: state_q <= StStep;
      endcase
    end
  end

  assign o_CPU_CE   = ce_q;
  assign o_HALTED   = halted_q;
  assign o_CE_COUNT = count_q;

endmodule
